// File: rtl/vga_timing_gen.sv
//============================================================================
// Module      : vga_timing_gen
// Description : 1280x720@60 raster timing generator. Free-running pixel and
//               line counters drive xaddr/yaddr to the sprite stages. Sync
//               and data-enable pass through a programmable delay line so
//               they meet sprite colour data after the sprite address
//               register plus BRAM read latency. Also provides a
//               once-per-frame vblank tick and an 8-bit frame counter.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int PIPE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] xaddr,
    output logic [9:0]  yaddr,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        vblank_tick,
    output logic [7:0]  frame_cnt
);

    // ------------------------------------------------------------------
    // Timing constants, held at full counter width so every compare is
    // unsigned and full-width.
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] c_H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0]  c_V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  c_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  c_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic        c_HS_IDLE    = ~HS_POL;
    localparam logic        c_VS_IDLE    = ~VS_POL;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        r_run;      // low for the first edge after reset release
    logic [10:0] r_hcnt;
    logic [9:0]  r_vcnt;
    logic [7:0]  r_frame_cnt;
    logic        r_tick;

    // Stage-0 timing registers, aligned with r_hcnt/r_vcnt.
    logic        r_hs_s0;
    logic        r_vs_s0;
    logic        r_de_s0;

    // ------------------------------------------------------------------
    // Next-count and decode logic
    // ------------------------------------------------------------------
    logic        w_h_last;
    logic        w_v_last;
    logic [10:0] w_hcnt_nxt;
    logic [9:0]  w_vcnt_nxt;
    logic        w_de_raw;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic        w_tick_raw;
    logic        w_frame_wrap;

    assign w_h_last     = (r_hcnt == c_H_LAST);
    assign w_v_last     = (r_vcnt == c_V_LAST);
    assign w_frame_wrap = r_run && w_h_last && w_v_last;

    // Compute the count that will be presented after this edge. The first
    // edge after reset release holds (0,0) so that the stage-0 timing
    // registers are loaded with the decode of pixel (0,0) at the same time
    // xaddr/yaddr present it; counting proper begins on the following edge.
    always_comb begin
        w_hcnt_nxt = 11'd0;
        w_vcnt_nxt = 10'd0;
        if (r_run) begin
            if (w_h_last) begin
                w_hcnt_nxt = 11'd0;
                w_vcnt_nxt = w_v_last ? 10'd0 : (r_vcnt + 10'd1);
            end else begin
                w_hcnt_nxt = r_hcnt + 11'd1;
                w_vcnt_nxt = r_vcnt;
            end
        end
    end

    // Decode raw timing from the upcoming count; registering it lines the
    // stage-0 outputs up with the registered xaddr/yaddr.
    assign w_de_raw   = (w_hcnt_nxt < c_H_ACT) && (w_vcnt_nxt < c_V_ACT);
    assign w_hs_raw   = (w_hcnt_nxt >= c_HS_START) && (w_hcnt_nxt < c_HS_END);
    assign w_vs_raw   = (w_vcnt_nxt >= c_VS_START) && (w_vcnt_nxt < c_VS_END);
    assign w_tick_raw = (w_hcnt_nxt == 11'd0) && (w_vcnt_nxt == c_V_ACT);

    // Counters, frame counter, vblank tick and stage-0 timing registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run       <= 1'b0;
            r_hcnt      <= 11'd0;
            r_vcnt      <= 10'd0;
            r_frame_cnt <= 8'd0;
            r_tick      <= 1'b0;
            r_hs_s0     <= c_HS_IDLE;
            r_vs_s0     <= c_VS_IDLE;
            r_de_s0     <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_hcnt  <= w_hcnt_nxt;
            r_vcnt  <= w_vcnt_nxt;
            r_tick  <= w_tick_raw;
            r_hs_s0 <= w_hs_raw ? HS_POL : c_HS_IDLE;
            r_vs_s0 <= w_vs_raw ? VS_POL : c_VS_IDLE;
            r_de_s0 <= w_de_raw;
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Programmable delay on hsync/vsync/de. Stages carry polarity-applied
    // values so reset fills every stage with the idle level and no stale
    // sync pulse can drain out after a reset.
    // ------------------------------------------------------------------
    generate
        if (PIPE_DLY > 0) begin : g_dly
            logic [PIPE_DLY-1:0] r_hs_dly;
            logic [PIPE_DLY-1:0] r_vs_dly;
            logic [PIPE_DLY-1:0] r_de_dly;

            // Shift the stage-0 timing through PIPE_DLY further registers.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_hs_dly <= {PIPE_DLY{c_HS_IDLE}};
                    r_vs_dly <= {PIPE_DLY{c_VS_IDLE}};
                    r_de_dly <= '0;
                end else begin
                    r_hs_dly[0] <= r_hs_s0;
                    r_vs_dly[0] <= r_vs_s0;
                    r_de_dly[0] <= r_de_s0;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        r_hs_dly[i] <= r_hs_dly[i-1];
                        r_vs_dly[i] <= r_vs_dly[i-1];
                        r_de_dly[i] <= r_de_dly[i-1];
                    end
                end
            end

            assign hsync = r_hs_dly[PIPE_DLY-1];
            assign vsync = r_vs_dly[PIPE_DLY-1];
            assign de    = r_de_dly[PIPE_DLY-1];
        end else begin : g_nodly
            assign hsync = r_hs_s0;
            assign vsync = r_vs_s0;
            assign de    = r_de_s0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Undelayed outputs
    // ------------------------------------------------------------------
    assign xaddr       = r_hcnt;
    assign yaddr       = r_vcnt;
    assign vblank_tick = r_tick;
    assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench for vga_timing_gen. Two
//               full-size instances (delay 0 and delay 2) cover line timing
//               and pipeline alignment; a reduced-raster instance (20x10
//               total, delay 2) covers whole-frame, wrap and reset cases
//               within a short run.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_gen;

    // Reduced raster: H 10+3+3+4 = 20, V 6+1+2+1 = 10, 200 clocks/frame.
    localparam int SH_TOT  = 20;
    localparam int S_FRAME = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Full-size, delay 0
    logic [10:0] a_x;  logic [9:0] a_y;
    logic a_hs, a_vs, a_de, a_tick;  logic [7:0] a_fc;
    // Full-size, delay 2
    logic [10:0] b_x;  logic [9:0] b_y;
    logic b_hs, b_vs, b_de, b_tick;  logic [7:0] b_fc;
    // Reduced raster, delay 2
    logic [10:0] s_x;  logic [9:0] s_y;
    logic s_hs, s_vs, s_de, s_tick;  logic [7:0] s_fc;

    vga_timing_gen #(.PIPE_DLY(0)) u_dut_a (
        .clk(clk), .rst(rst), .xaddr(a_x), .yaddr(a_y), .hsync(a_hs),
        .vsync(a_vs), .de(a_de), .vblank_tick(a_tick), .frame_cnt(a_fc));

    vga_timing_gen #(.PIPE_DLY(2)) u_dut_b (
        .clk(clk), .rst(rst), .xaddr(b_x), .yaddr(b_y), .hsync(b_hs),
        .vsync(b_vs), .de(b_de), .vblank_tick(b_tick), .frame_cnt(b_fc));

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(3), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DLY(2)
    ) u_dut_s (
        .clk(clk), .rst(rst), .xaddr(s_x), .yaddr(s_y), .hsync(s_hs),
        .vsync(s_vs), .de(s_de), .vblank_tick(s_tick), .frame_cnt(s_fc));

    // Hold reset 5 clocks, check idle outputs, release and check (0,0).
    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (a_hs !== 1'b0) begin n_errors++; $display("FAIL reset_hsync: got %b expected 0", a_hs); end
        n_checks++; if (a_vs !== 1'b0) begin n_errors++; $display("FAIL reset_vsync: got %b expected 0", a_vs); end
        n_checks++; if (a_de !== 1'b0) begin n_errors++; $display("FAIL reset_de: got %b expected 0", a_de); end
        n_checks++; if (a_fc !== 8'd0) begin n_errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", a_fc); end
        n_checks++; if (a_tick !== 1'b0) begin n_errors++; $display("FAIL reset_tick: got %b expected 0", a_tick); end
        n_checks++; if (b_hs !== 1'b0 || b_de !== 1'b0) begin n_errors++; $display("FAIL reset_dly_outputs: got hs=%b de=%b expected 0 0", b_hs, b_de); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (a_x !== 11'd0 || a_y !== 10'd0) begin n_errors++; $display("FAIL release_addr: got (%0d,%0d) expected (0,0)", a_x, a_y); end
        n_checks++; if (a_de !== 1'b1) begin n_errors++; $display("FAIL release_de_aligned: got %b expected 1", a_de); end
    endtask

    // Delay-2 instance: de and hsync lag their counts by exactly 2 clocks.
    task automatic test_pipe_align();
        int guard;
        n_checks++; if (b_x !== 11'd0 || b_de !== 1'b0) begin n_errors++; $display("FAIL align_x0: got x=%0d de=%b expected x=0 de=0", b_x, b_de); end
        @(negedge clk);
        n_checks++; if (b_x !== 11'd1 || b_de !== 1'b0) begin n_errors++; $display("FAIL align_x1: got x=%0d de=%b expected x=1 de=0", b_x, b_de); end
        @(negedge clk);
        n_checks++; if (b_x !== 11'd2 || b_de !== 1'b1) begin n_errors++; $display("FAIL align_de_rise: got x=%0d de=%b expected x=2 de=1", b_x, b_de); end
        guard = 0;
        while (b_x !== 11'd1390 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (guard >= 2000) begin n_errors++; $display("FAIL align_wait_1390: got timeout expected xaddr 1390"); end
        n_checks++; if (b_hs !== 1'b0) begin n_errors++; $display("FAIL align_hs_at_1390: got %b expected 0", b_hs); end
        @(negedge clk);
        n_checks++; if (b_hs !== 1'b0) begin n_errors++; $display("FAIL align_hs_at_1391: got %b expected 0", b_hs); end
        @(negedge clk);
        n_checks++; if (b_hs !== 1'b1 || b_x !== 11'd1392) begin n_errors++; $display("FAIL align_hs_rise: got x=%0d hs=%b expected x=1392 hs=1", b_x, b_hs); end
    endtask

    // Delay-0 instance: one full active line, period and windows.
    task automatic test_line_timing();
        int guard, de_cnt, hs_cnt, hs_first, bad;
        guard = 0;
        while (!(a_x === 11'd0 && a_y === 10'd2) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (guard >= 5000) begin n_errors++; $display("FAIL line_wait_start: got timeout expected (0,2)"); end
        de_cnt = 0; hs_cnt = 0; hs_first = -1; bad = 0;
        for (int i = 0; i < 1650; i++) begin
            if (a_de === 1'b1) de_cnt++;
            if (a_hs === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (a_de !== (i < 1280)) bad++;
            if (a_hs !== (i >= 1390 && i < 1430)) bad++;
            if (a_vs !== 1'b0) bad++;
            if (a_x !== 11'(i) || a_y !== 10'd2) bad++;
            @(negedge clk);
        end
        n_checks++; if (de_cnt != 1280) begin n_errors++; $display("FAIL line_de_count: got %0d expected 1280", de_cnt); end
        n_checks++; if (hs_cnt != 40) begin n_errors++; $display("FAIL line_hs_count: got %0d expected 40", hs_cnt); end
        n_checks++; if (hs_first != 1390) begin n_errors++; $display("FAIL line_hs_start: got %0d expected 1390", hs_first); end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL line_per_clock: got %0d bad clocks expected 0", bad); end
        n_checks++; if (a_x !== 11'd0 || a_y !== 10'd3) begin n_errors++; $display("FAIL line_period: got (%0d,%0d) expected (0,3)", a_x, a_y); end
    endtask

    // Reduced raster: one whole frame against a delayed-decode model.
    task automatic test_frame_timing();
        int guard, de_cnt, vs_cnt, tick_cnt, tick_pos, lines, bad, j, jx, jy;
        guard = 0;
        while (!(s_x === 11'd0 && s_y === 10'd0) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (guard >= 400) begin n_errors++; $display("FAIL frame_wait_start: got timeout expected (0,0)"); end
        de_cnt = 0; vs_cnt = 0; tick_cnt = 0; tick_pos = -1; lines = 0; bad = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            j  = (i + S_FRAME - 2) % S_FRAME;
            jx = j % SH_TOT;
            jy = j / SH_TOT;
            if (s_de === 1'b1) de_cnt++;
            if (s_vs === 1'b1) vs_cnt++;
            if (s_x === 11'd0) lines++;
            if (s_tick === 1'b1) begin
                tick_cnt++;
                tick_pos = i;
            end
            if (s_de !== (jx < 10 && jy < 6)) bad++;
            if (s_hs !== (jx >= 13 && jx < 16)) bad++;
            if (s_vs !== (jy >= 7 && jy < 9)) bad++;
            if (s_x !== 11'(i % SH_TOT) || s_y !== 10'(i / SH_TOT)) bad++;
            @(negedge clk);
        end
        n_checks++; if (lines != 10) begin n_errors++; $display("FAIL frame_lines: got %0d expected 10", lines); end
        n_checks++; if (de_cnt != 60) begin n_errors++; $display("FAIL frame_de_count: got %0d expected 60", de_cnt); end
        n_checks++; if (vs_cnt != 40) begin n_errors++; $display("FAIL frame_vs_count: got %0d expected 40", vs_cnt); end
        n_checks++; if (tick_cnt != 1) begin n_errors++; $display("FAIL frame_tick_count: got %0d expected 1", tick_cnt); end
        n_checks++; if (tick_pos != 120) begin n_errors++; $display("FAIL frame_tick_pos: got %0d expected 120 (x=0,y=6)", tick_pos); end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL frame_per_clock: got %0d bad clocks expected 0", bad); end
        n_checks++; if (s_x !== 11'd0 || s_y !== 10'd0) begin n_errors++; $display("FAIL frame_wrap_addr: got (%0d,%0d) expected (0,0)", s_x, s_y); end
    endtask

    // Reduced raster: 257 frames from reset, frame_cnt 255 -> 0 -> 1.
    task automatic test_wrap();
        int bad;
        bad = 0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (s_fc !== 8'd0) begin n_errors++; $display("FAIL wrap_start: got %0d expected 0", s_fc); end
        for (int n = 1; n <= 257; n++) begin
            repeat (S_FRAME) @(negedge clk);
            if (n >= 255) begin
                n_checks++; if (s_fc !== 8'(n)) begin n_errors++; $display("FAIL wrap_frame_cnt_%0d: got %0d expected %0d", n, s_fc, n % 256); end
                n_checks++; if (s_x !== 11'd0 || s_y !== 10'd0) begin n_errors++; $display("FAIL wrap_addr_%0d: got (%0d,%0d) expected (0,0)", n, s_x, s_y); end
            end else if (s_fc !== 8'(n)) begin
                bad++;
            end
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL wrap_intermediate: got %0d bad frames expected 0", bad); end
    endtask

    // Reduced raster: single-clock reset while hsync and vsync are active.
    task automatic test_reset_mid_sync();
        int bad;
        bool_wait: begin
            repeat (175) @(negedge clk);
        end
        n_checks++; if (s_x !== 11'd15 || s_y !== 10'd8 || s_hs !== 1'b1 || s_vs !== 1'b1) begin
            n_errors++; $display("FAIL midsync_pre: got x=%0d y=%0d hs=%b vs=%b expected 15 8 1 1", s_x, s_y, s_hs, s_vs);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (s_x !== 11'd0 || s_y !== 10'd0 || s_fc !== 8'd0) begin
            n_errors++; $display("FAIL midsync_reset_cnt: got x=%0d y=%0d fc=%0d expected 0 0 0", s_x, s_y, s_fc);
        end
        n_checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0 || s_de !== 1'b0 || s_tick !== 1'b0) begin
            n_errors++; $display("FAIL midsync_reset_out: got hs=%b vs=%b de=%b tick=%b expected 0 0 0 0", s_hs, s_vs, s_de, s_tick);
        end
        rst = 1'b1;
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (s_hs !== (k >= 16 && k <= 18)) bad++;
            if (s_de !== (k >= 3 && k <= 12)) bad++;
            if (s_vs !== 1'b0) bad++;
            if (s_x !== 11'(k - 1)) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL midsync_restart: got %0d bad clocks expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_pipe_align();
        test_line_timing();
        test_frame_timing();
        test_wrap();
        test_reset_mid_sync();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound in case the sequence above stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
